cache_level_split_responder: RTL

CACHE_LEVEL_SPLIT_RESPONDER -- requirements
Module: cache_level_split_responder

---
 rtl/cache_level_split_responder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/cache_level_split_responder.sv
// Issues one latched request to the next cache level and waits for mem_resp.
// Reports a one-cycle completion, the captured read line and the issue latency.
module cache_level_split_responder (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  req_address,
  input  logic [127:0] req_data,
  input  logic         req_read,
  input  logic         req_write,
  output logic         req_load,
  output logic [15:0]  mem_address,
  output logic [127:0] mem_wdata,
  output logic         mem_read,
  output logic         mem_write,
  input  logic         mem_resp,
  input  logic [127:0] mem_rdata,
  output logic         resp_out,
  output logic [127:0] rdata_out,
  output logic [15:0]  last_latency
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [15:0]  addr_q;
  logic [127:0] data_q;
  logic         wr_q;
  logic [15:0]  cnt_q;
  logic [15:0]  cnt_inc;
  logic         req_any;
  logic         accept;
  logic         finish;

  assign req_any = req_read | req_write;
  assign accept  = (state == IDLE) & req_any;
  assign finish  = (state == ISSUE) & mem_resp;

  // Counter value including the current ISSUE cycle, saturated.
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  // Operands always come from the latched copy.
  assign mem_address = addr_q;
  assign mem_wdata   = data_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and handshake strobes.
  always_comb begin
    state_nx  = state;
    req_load  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    resp_out  = 1'b0;
    unique case (state)
      IDLE: begin
        req_load = ~req_any;
        if (req_any) begin
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        mem_read  = ~wr_q;
        mem_write = wr_q;
        if (mem_resp) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        req_load = 1'b1;
        resp_out = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Request latch; a simultaneous read+write is kept as a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= 16'h0;
      data_q <= 128'h0;
      wr_q   <= 1'b0;
    end else if (accept) begin
      addr_q <= req_address;
      data_q <= req_data;
      wr_q   <= req_write;
    end
  end

  // Issue-cycle counter, cleared once the completion is reported.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 16'h0;
    end else if (state == ISSUE) begin
      cnt_q <= cnt_inc;
    end else if (state == DONE) begin
      cnt_q <= 16'h0;
    end
  end

  // Completion capture: latency always, read line only for reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_out    <= 128'h0;
      last_latency <= 16'h0;
    end else if (finish) begin
      last_latency <= cnt_inc;
      if (!wr_q) begin
        rdata_out <= mem_rdata;
      end
    end
  end

endmodule
